load_store_unit: RTL and testbench

//  Memory stage between the single-cycle core's ALU/decoder and a multi-cycle data memory.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_align.sv | 79 +++++++
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: access-size encodings taken
// straight from inst[14:12] and the FSM state encoding.
package lsu_pkg;

    // funct3 access sizes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // FSM states
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// Purely combinational lane logic for the load/store unit.
// The request side works on the live decoder inputs (byte enables, store
// replication, misalign/illegal detection); the response side works on the
// registered size/offset to pick and extend the loaded lane.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_offset,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    output logic [3:0]  req_be,
    output logic [31:0] req_store_data,
    output logic        req_bad,
    input  logic [2:0]  rsp_funct3,
    input  logic [1:0]  rsp_offset,
    input  logic [31:0] rsp_word,
    output logic [31:0] rsp_load_data
);

    logic        misaligned;
    logic        illegal;
    logic [7:0]  word_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign word_lane[gi] = rsp_word[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = word_lane[rsp_offset];
    assign half_sel = rsp_offset[1] ? rsp_word[31:16] : rsp_word[15:0];

    // Byte enables, lane replication and legality of the incoming request
    always_comb begin
        req_be         = 4'b0000;
        req_store_data = req_wdata;
        misaligned     = 1'b0;
        illegal        = 1'b0;
        case (req_funct3)
            F3_B, F3_BU: begin
                req_be         = 4'b0001 << req_offset;
                req_store_data = {4{req_wdata[7:0]}};
                // unsigned loads have no store counterpart
                illegal        = req_we && (req_funct3 == F3_BU);
            end
            F3_H, F3_HU: begin
                req_be         = 4'b0011 << {req_offset[1], 1'b0};
                req_store_data = {2{req_wdata[15:0]}};
                misaligned     = req_offset[0];
                illegal        = req_we && (req_funct3 == F3_HU);
            end
            F3_W: begin
                req_be         = 4'b1111;
                misaligned     = |req_offset;
            end
            default: begin
                illegal        = 1'b1;
            end
        endcase
        req_bad = misaligned | illegal;
    end

    // Lane selection and sign/zero extension of the returned word
    always_comb begin
        rsp_load_data = rsp_word;
        case (rsp_funct3)
            F3_B:    rsp_load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rsp_load_data = {24'h000000, byte_sel};
            F3_H:    rsp_load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rsp_load_data = {16'h0000, half_sel};
            default: rsp_load_data = rsp_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage between a single-cycle core and a multi-cycle data memory.
// Captures one load/store in IDLE, runs a req/gnt(/rvalid) handshake on a
// word-addressed port, and releases the core with a one-cycle done pulse.
// Both handshake phases are bounded by TIMEOUT cycles.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              stall_o,
    output logic              done_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i
);

    localparam int             CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ADDR_W-3:0] addr_reg;
    logic [1:0]        offset_reg;
    logic [3:0]        be_reg;
    logic [31:0]       wdata_reg;
    logic              we_reg;
    logic [2:0]        funct3_reg;
    logic              err_reg;
    logic [31:0]       rdata_reg;

    logic              access;
    logic              timed_out;
    logic [3:0]        align_be;
    logic [31:0]       align_store;
    logic              align_bad;
    logic [31:0]       align_load;

    // a store wins when the decoder raises both strobes
    assign access    = memread_i | memwrite_i;
    assign timed_out = (cnt_reg == CNT_LAST);

    lsu_align u_align (
        .req_funct3     (funct3_i),
        .req_offset     (address_i[1:0]),
        .req_we         (memwrite_i),
        .req_wdata      (wdata_i),
        .req_be         (align_be),
        .req_store_data (align_store),
        .req_bad        (align_bad),
        .rsp_funct3     (funct3_reg),
        .rsp_offset     (offset_reg),
        .rsp_word       (mem_rdata_i),
        .rsp_load_data  (align_load)
    );

    // Next-state decision; grant and rvalid take priority over a timeout
    // landing in the same cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (access) state_next = align_bad ? DONE : REQ;
            REQ: begin
                if (mem_gnt_i)      state_next = we_reg ? DONE : WAIT;
                else if (timed_out) state_next = DONE;
            end
            WAIT: if (mem_rvalid_i || timed_out) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and per-state cycle counter, cleared on every state entry
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg)
                cnt_reg <= '0;
            else if (state_reg == REQ || state_reg == WAIT)
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Request capture in IDLE, error flagging and load data capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_reg   <= '0;
            offset_reg <= '0;
            be_reg     <= '0;
            wdata_reg  <= '0;
            we_reg     <= 1'b0;
            funct3_reg <= '0;
            err_reg    <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (access) begin
                        addr_reg   <= address_i[ADDR_W-1:2];
                        offset_reg <= address_i[1:0];
                        be_reg     <= align_be;
                        wdata_reg  <= align_store;
                        we_reg     <= memwrite_i;
                        funct3_reg <= funct3_i;
                        err_reg    <= align_bad;
                        rdata_reg  <= '0;
                    end
                end
                REQ: begin
                    if (!mem_gnt_i && timed_out) err_reg <= 1'b1;
                end
                WAIT: begin
                    if (mem_rvalid_i)   rdata_reg <= align_load;
                    else if (timed_out) err_reg   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_req_o   = (state_reg == REQ);
    assign mem_we_o    = we_reg;
    assign mem_addr_o  = addr_reg;
    assign mem_be_o    = be_reg;
    assign mem_wdata_o = wdata_reg;

    assign done_o  = (state_reg == DONE);
    assign err_o   = done_o & err_reg;
    assign rdata_o = done_o ? rdata_reg : 32'h0;
    assign stall_o = access & (state_reg != DONE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit. Each transaction's expected cycle
// timeline and data are derived from the access rules (size, alignment,
// handshake delays, timeout bound); a negedge process compares every cycle.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        memread_i, memwrite_i;
    logic [2:0]  funct3_i;
    logic [31:0] address_i, wdata_i;
    logic [31:0] rdata_o;
    logic        stall_o, done_o, err_o;
    logic        mem_req_o, mem_we_o;
    logic [29:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    load_store_unit #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .memread_i    (memread_i),
        .memwrite_i   (memwrite_i),
        .funct3_i     (funct3_i),
        .address_i    (address_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // per-cycle expectations
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_done, exp_err, exp_req, exp_we, exp_zero;
    logic [31:0] exp_rdata, exp_wdata;
    logic [29:0] exp_addr;
    logic [3:0]  exp_be;

    int          done_count = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    // model outputs used by the literal pins
    logic        m_bad;
    logic [3:0]  m_be;
    logic [31:0] m_sd, m_ld;
    int          base_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Access rules expressed arithmetically: size in bytes, offset within word
    function automatic void ref_access(input logic we, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] wd,
                                       input logic [31:0] word,
                                       output logic bad, output logic [3:0] be,
                                       output logic [31:0] sd, output logic [31:0] ld);
        int sz, off;
        logic sgn, legal;
        logic [31:0] mask, v;
        off = int'(a[1:0]);
        sz = 1; sgn = 1'b0; legal = 1'b1;
        case (f3)
            3'b000: begin sz = 1; sgn = 1'b1; end
            3'b001: begin sz = 2; sgn = 1'b1; end
            3'b010: begin sz = 4; end
            3'b100: begin sz = 1; legal = !we; end
            3'b101: begin sz = 2; legal = !we; end
            default: legal = 1'b0;
        endcase
        bad = !legal || ((off % sz) != 0);
        be = 4'(((1 << sz) - 1) << off);
        for (int i = 0; i < 4; i++) sd[8*i +: 8] = wd[8*(i % sz) +: 8];
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
        v = (word >> (8*off)) & mask;
        if (sgn && sz < 4 && v[8*sz-1]) v = v | ~mask;
        ld = v;
    endfunction

    // Compare process: every cycle while checking is enabled
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("stall", 32'(stall_o), 32'(exp_stall));
            check("done",  32'(done_o),  32'(exp_done));
            check("err",   32'(err_o),   32'(exp_err));
            check("rdata", rdata_o,      exp_rdata);
            check("req",   32'(mem_req_o), 32'(exp_req));
            if (exp_req || exp_zero) begin
                check("mem_we",    32'(mem_we_o),   exp_zero ? 32'd0 : 32'(exp_we));
                check("mem_addr",  32'(mem_addr_o), exp_zero ? 32'd0 : 32'(exp_addr));
                check("mem_be",    32'(mem_be_o),   exp_zero ? 32'd0 : 32'(exp_be));
                check("mem_wdata", mem_wdata_o,     exp_zero ? 32'd0 : exp_wdata);
            end
            if (done_o === 1'b1) begin
                done_count++;
                last_rdata = rdata_o;
                last_err   = err_o;
            end
        end
    end

    task automatic set_quiet_exp(input logic zero);
        exp_stall = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_rdata = 32'h0;
        exp_req = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_be = '0; exp_wdata = '0;
        exp_zero = zero;
    endtask

    // One access: gnt arrives gnt_dly cycles into REQ, rvalid rv_dly cycles after gnt
    task automatic run_txn(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input int gnt_dly, input int rv_dly, input logic [31:0] word,
                           input logic stale);
        logic bad, granted, to_err, we, in_req, in_wait, real_rv;
        logic [3:0] be;
        logic [31:0] sd, ld, rd_exp;
        int n_req, n_wait, done_k;
        we = wr;
        ref_access(we, f3, a, wd, word, bad, be, sd, ld);
        n_req = 0; n_wait = 0; granted = 1'b0; to_err = 1'b0;
        if (!bad) begin
            if (gnt_dly + 1 <= TO) begin n_req = gnt_dly + 1; granted = 1'b1; end
            else begin n_req = TO; to_err = 1'b1; end
            if (granted && !we) begin
                if (rv_dly <= TO) n_wait = rv_dly;
                else begin n_wait = TO; to_err = 1'b1; end
            end
        end
        done_k = 1 + n_req + n_wait;
        rd_exp = (bad || to_err || we) ? 32'h0 : ld;
        for (int k = 0; k <= done_k; k++) begin
            memread_i  = rd;
            memwrite_i = wr;
            if (k == 0) begin
                funct3_i = f3; address_i = a; wdata_i = wd;
            end else begin
                funct3_i = 3'($urandom); address_i = $urandom; wdata_i = $urandom;
            end
            in_req  = !bad && (k >= 1) && (k <= n_req);
            in_wait = (k > n_req) && (k <= n_req + n_wait);
            real_rv = in_wait && !to_err && (k == n_req + n_wait);
            mem_gnt_i    = in_req && granted && (k == n_req);
            mem_rvalid_i = real_rv || (stale && !in_wait);
            mem_rdata_i  = real_rv ? word : $urandom;
            exp_stall = (k != done_k);
            exp_done  = (k == done_k);
            exp_err   = exp_done && (bad || to_err);
            exp_rdata = exp_done ? rd_exp : 32'h0;
            exp_req   = in_req;
            exp_we    = we;
            exp_addr  = a[31:2];
            exp_be    = be;
            exp_wdata = sd;
            exp_zero  = 1'b0;
            chk_en    = 1'b1;
            @(posedge clk_i); #1;
        end
        memread_i = 1'b0; memwrite_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        set_quiet_exp(1'b0);
        @(posedge clk_i); #1;
        $display("[TB] txn %s: rd=%0b wr=%0b f3=%03b addr=%h -> done in cycle %0d err=%0b rdata=%h",
                 tag, rd, wr, f3, a, done_k + 1, bad || to_err, rd_exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at t=%0t, limit 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        memread_i = 1'b0; memwrite_i = 1'b0; funct3_i = 3'b000;
        address_i = 32'h0; wdata_i = 32'h0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        set_quiet_exp(1'b1);

        // Pin the model against hand-computed values
        ref_access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, m_bad, m_be, m_sd, m_ld);
        check("model_sw_be", 32'(m_be), 32'h0000_000F);
        check("model_sw_data", m_sd, 32'hDEADBEEF);
        ref_access(1'b1, 3'b000, 32'h13, 32'h0000_00A5, 32'h0, m_bad, m_be, m_sd, m_ld);
        check("model_sb_be", 32'(m_be), 32'h0000_0008);
        check("model_sb_data", m_sd, 32'hA5A5A5A5);
        ref_access(1'b0, 3'b000, 32'h02, 32'h0, 32'h0080_0000, m_bad, m_be, m_sd, m_ld);
        check("model_lb", m_ld, 32'hFFFF_FF80);
        ref_access(1'b0, 3'b100, 32'h02, 32'h0, 32'h0080_0000, m_bad, m_be, m_sd, m_ld);
        check("model_lbu", m_ld, 32'h0000_0080);
        ref_access(1'b0, 3'b001, 32'h03, 32'h0, 32'h0, m_bad, m_be, m_sd, m_ld);
        check("model_lh_mis", 32'(m_bad), 32'd1);

        // Reset: all outputs zero
        @(posedge clk_i); #1;
        chk_en = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        run_txn("sw",       1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 1'b0);
        run_txn("sb",       1'b0, 1'b1, 3'b000, 32'h13, 32'h0000_00A5, 0, 0, 32'h0, 1'b0);
        run_txn("sh",       1'b0, 1'b1, 3'b001, 32'h06, 32'h1234ABCD, 2, 0, 32'h0, 1'b0);
        run_txn("lb",       1'b1, 1'b0, 3'b000, 32'h02, 32'h0, 0, 1, 32'h0080_0000, 1'b0);
        check("lb_rdata", last_rdata, 32'hFFFF_FF80);
        run_txn("lbu",      1'b1, 1'b0, 3'b100, 32'h02, 32'h0, 0, 1, 32'h0080_0000, 1'b0);
        check("lbu_rdata", last_rdata, 32'h0000_0080);
        run_txn("lh_mis",   1'b1, 1'b0, 3'b001, 32'h03, 32'h0, 0, 1, 32'h0, 1'b1);
        check("lh_mis_err", 32'(last_err), 32'd1);
        run_txn("f3_011",   1'b1, 1'b0, 3'b011, 32'h00, 32'h0, 0, 1, 32'h0, 1'b0);
        run_txn("sbu_ill",  1'b0, 1'b1, 3'b100, 32'h01, 32'h55, 0, 0, 32'h0, 1'b0);
        run_txn("sw_mis",   1'b0, 1'b1, 3'b010, 32'h22, 32'h55, 0, 0, 32'h0, 1'b0);
        run_txn("lhu",      1'b1, 1'b0, 3'b101, 32'h02, 32'h0, 1, 1, 32'h8001_0000, 1'b0);
        run_txn("lh",       1'b1, 1'b0, 3'b001, 32'h02, 32'h0, 0, 3, 32'h8001_0000, 1'b0);
        check("lh_rdata", last_rdata, 32'hFFFF_8001);
        base_cnt = done_count;
        run_txn("lw_slow",  1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 3, 2, 32'hCAFEF00D, 1'b1);
        check("lw_slow_done_once", 32'(done_count - base_cnt), 32'd1);
        check("lw_slow_rdata", last_rdata, 32'hCAFEF00D);
        run_txn("rw_both",  1'b1, 1'b1, 3'b010, 32'h80, 32'h01020304, 0, 1, 32'h0, 1'b0);
        run_txn("lw_edge",  1'b1, 1'b0, 3'b010, 32'h0C, 32'h0, TO - 1, TO, 32'h1357_9BDF, 1'b0);
        run_txn("lw_nognt", 1'b1, 1'b0, 3'b010, 32'h0C, 32'h0, 100, 1, 32'h0, 1'b1);
        check("lw_nognt_err", 32'(last_err), 32'd1);
        run_txn("lw_norv",  1'b1, 1'b0, 3'b010, 32'h18, 32'h0, 0, 100, 32'h0, 1'b1);
        run_txn("sw_nognt", 1'b0, 1'b1, 3'b010, 32'h18, 32'h77, TO, 0, 32'h0, 1'b0);

        // Reset while in WAIT, then a late rvalid must be ignored
        base_cnt = done_count;
        memread_i = 1'b1; memwrite_i = 1'b0; funct3_i = 3'b010;
        address_i = 32'h20; wdata_i = 32'h0;
        set_quiet_exp(1'b0);
        exp_stall = 1'b1;
        @(posedge clk_i); #1;
        mem_gnt_i = 1'b1;
        exp_req = 1'b1; exp_we = 1'b0; exp_addr = 30'h8; exp_be = 4'hF; exp_wdata = 32'h0;
        @(posedge clk_i); #1;
        mem_gnt_i = 1'b0; rst_i = 1'b1; memread_i = 1'b0;
        set_quiet_exp(1'b0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        set_quiet_exp(1'b1);
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0;
        @(posedge clk_i); #1;
        chk_en = 1'b0;
        check("rst_no_done", 32'(done_count - base_cnt), 32'd0);
        $display("[TB] txn rst_in_wait: lw @00000020 aborted by reset, late rvalid ignored");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
